// File: rtl/waterfall_line_writer.sv
// Packs ADC samples into ping-pong line buffers and, during lower blanking, copies one full line
// into the scrolling frame buffer row at y_offset. Zero-fills the frame buffer after reset.
module waterfall_line_writer #(
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned LINE_WIDTH   = 320,
  parameter int unsigned LINES        = 240,
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned SCROLL_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    adc_ready,
  input  logic                    lower_blank,
  output logic [ADDR_WIDTH-1:0]   fb_addr,
  output logic [7:0]              fb_wdata,
  output logic                    fb_we,
  output logic                    fb_busy,
  output logic [7:0]              y_offset,
  output logic                    overrun
);
  localparam int unsigned IdxW   = $clog2(LINE_WIDTH + 1);
  localparam int unsigned MemW   = $clog2(LINE_WIDTH);
  localparam int unsigned FrameW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(LINES * LINE_WIDTH - 1);
  localparam logic [IdxW-1:0]       LastIdx   = IdxW'(LINE_WIDTH - 1);
  localparam logic [IdxW-1:0]       EndIdx    = IdxW'(LINE_WIDTH);
  localparam logic [FrameW-1:0]     LastFrame = FrameW'(SCROLL_DIV - 1);
  localparam logic [7:0]            LastRow   = 8'(LINES - 1);

  typedef enum logic [1:0] {StClear, StIdle, StWrite, StWaitActive} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [FrameW-1:0]     frame_q, frame_d;
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [7:0]            y_offset_q, y_offset_d;
  logic                  lb_q;
  logic [IdxW-1:0]       cap_idx_q, cap_idx_d;
  logic                  cap_bank_q, cap_bank_d;
  logic [1:0]            full_q, full_d;
  logic                  stall_q, stall_d;
  logic                  overrun_q, overrun_d;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]            fb_wdata_q, fb_wdata_d;
  logic                  fb_we_q, fb_we_d;
  logic                  fb_busy_q, fb_busy_d;

  logic [7:0]            lbuf_q [2][LINE_WIDTH];
  logic                  mem_we;
  logic                  mem_bank;
  logic [IdxW-1:0]       mem_idx;
  logic [7:0]            pixel, rd_word;
  logic [1:0]            release_mask;
  logic                  blank_rise, oldest;
  logic [ADDR_WIDTH-1:0] row_base;
  logic                  unused_adc;

  assign pixel      = adc_data[SAMPLE_WIDTH-1 -: 8];
  assign unused_adc = ^adc_data[SAMPLE_WIDTH-9:0];
  assign blank_rise = lower_blank & ~lb_q;
  // Both banks full only happens while stalled, where cap_bank holds the newer line.
  assign oldest     = (&full_q) ? ~cap_bank_q : ~full_q[0];
  assign row_base   = ADDR_WIDTH'(y_offset_q) * ADDR_WIDTH'(LINE_WIDTH);
  assign rd_word    = lbuf_q[wr_bank_q][rd_idx_q[MemW-1:0]];

  always_ff @(posedge clk) begin
    if (mem_we) lbuf_q[mem_bank][mem_idx[MemW-1:0]] <= pixel;
  end

  // Capture: a bank released this cycle is treated as empty before the sample is handled.
  always_comb begin
    full_d     = full_q & ~release_mask;
    cap_idx_d  = cap_idx_q;
    cap_bank_d = cap_bank_q;
    stall_d    = stall_q;
    overrun_d  = overrun_q;
    mem_we     = 1'b0;
    if (stall_q && !full_d[~cap_bank_q]) begin
      cap_bank_d = ~cap_bank_q;
      stall_d    = 1'b0;
      cap_idx_d  = '0;
    end
    mem_bank = cap_bank_d;
    mem_idx  = cap_idx_d;
    if (adc_ready) begin
      if (stall_d) begin
        overrun_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        if (cap_idx_d == LastIdx) begin
          full_d[cap_bank_d] = 1'b1;
          cap_idx_d          = '0;
          if (full_d[~cap_bank_d]) stall_d = 1'b1;
          else                     cap_bank_d = ~cap_bank_d;
        end else begin
          cap_idx_d = cap_idx_d + IdxW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StClear;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear:      if (clr_cnt_q == LastAddr) state_d = StIdle;
      StIdle:       if (blank_rise && frame_q == LastFrame && |full_q) state_d = StWrite;
      StWrite:      if (rd_idx_q == EndIdx) state_d = StWaitActive;
      StWaitActive: if (!lower_blank) state_d = StIdle;
      default:      state_d = StClear;
    endcase
  end

  always_comb begin
    clr_cnt_d    = clr_cnt_q;
    frame_d      = frame_q;
    rd_idx_d     = rd_idx_q;
    wr_bank_d    = wr_bank_q;
    y_offset_d   = y_offset_q;
    release_mask = 2'b00;
    unique case (state_q)
      StClear: clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      StIdle: begin
        if (blank_rise) begin
          frame_d   = (frame_q == LastFrame) ? '0 : frame_q + FrameW'(1);
          rd_idx_d  = '0;
          wr_bank_d = oldest;
        end
      end
      StWrite: begin
        if (rd_idx_q == EndIdx) begin
          release_mask[wr_bank_q] = 1'b1;
          y_offset_d = (y_offset_q == LastRow) ? 8'd0 : y_offset_q + 8'd1;
        end else begin
          rd_idx_d = rd_idx_q + IdxW'(1);
        end
      end
      default: ;
    endcase
  end

  // Frame buffer outputs are registered, so the write beat trails the read index by one cycle.
  always_comb begin
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = 8'h00;
    fb_busy_d  = (state_q == StClear) || (state_d == StWrite);
    unique case (state_q)
      StClear: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_cnt_q;
      end
      StWrite: begin
        if (rd_idx_q < EndIdx) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = row_base + ADDR_WIDTH'(rd_idx_q);
          fb_wdata_d = rd_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_cnt_q  <= '0;
      frame_q    <= '0;
      rd_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      y_offset_q <= 8'd0;
      lb_q       <= 1'b0;
      cap_idx_q  <= '0;
      cap_bank_q <= 1'b0;
      full_q     <= 2'b00;
      stall_q    <= 1'b0;
      overrun_q  <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= 8'h00;
      fb_we_q    <= 1'b0;
      fb_busy_q  <= 1'b1;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      frame_q    <= frame_d;
      rd_idx_q   <= rd_idx_d;
      wr_bank_q  <= wr_bank_d;
      y_offset_q <= y_offset_d;
      lb_q       <= lower_blank;
      cap_idx_q  <= cap_idx_d;
      cap_bank_q <= cap_bank_d;
      full_q     <= full_d;
      stall_q    <= stall_d;
      overrun_q  <= overrun_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      fb_we_q    <= fb_we_d;
      fb_busy_q  <= fb_busy_d;
    end
  end

  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign fb_we    = fb_we_q;
  assign fb_busy  = fb_busy_q;
  assign y_offset = y_offset_q;
  assign overrun  = overrun_q;

endmodule
